lfsr_checker: RTL and testbench

- Serial pseudo-random sequence checker; the receive-side counterpart of the team's Galois LFSR generator.
- Consumes the generator's feedback/output bit (q[N-1]) one bit per valid cycle and self-synchronises to the sequence.
- Once locked, predicts every following bit and counts mismatches. Sits at the far end of the serial link or loopback path under test.

---
 rtl/lfsr_pkg.sv | 38 +++
 rtl/lfsr_checker_if.sv | 29 ++
 rtl/lfsr_history.sv | 50 +++++
 rtl/lfsr_checker.sv | 160 ++++++++++++++++
 tb/tb_lfsr_checker.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// ----------------------------------------------------------------------------
// lfsr_pkg
// Definitions shared by the LFSR sequence checker and its generator
// counterpart.
//   state_e       : checker synchronisation state (fill, verify, locked)
//   LFSR_N/TAP_*  : default polynomial x^20 + x^19 + x^2 + 1
//   lfsr_predict  : next-bit prediction from a history vector (newest bit
//                   at index 0), valid for any N up to LFSR_MAX_N
// ----------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam int LFSR_N     = 20;
    localparam int LFSR_TAP_A = 2;
    localparam int LFSR_TAP_B = 19;
    localparam int LFSR_MAX_N = 64;

    // s(t) = s(t-(n-tap_b)) ^ s(t-(n-tap_a)) ^ s(t-n). Shifting rather than
    // indexing keeps the selects width-clean for any integer tap value.
    function automatic logic lfsr_predict(input logic [LFSR_MAX_N-1:0] h,
                                          input int n,
                                          input int tap_a,
                                          input int tap_b);
        logic [LFSR_MAX_N-1:0] s_b;
        logic [LFSR_MAX_N-1:0] s_a;
        logic [LFSR_MAX_N-1:0] s_n;
        s_b = h >> (n - tap_b - 1);
        s_a = h >> (n - tap_a - 1);
        s_n = h >> (n - 1);
        return s_b[0] ^ s_a[0] ^ s_n[0];
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// ----------------------------------------------------------------------------
// lfsr_checker_if
// Serial receive and status bundle of the LFSR sequence checker.
//   din, din_valid : received bit and its qualifier (source -> checker)
//   clr_cnt        : synchronous clear of the error counter
//   locked, err    : synchronisation status and one-cycle mismatch pulse
//   err_count      : saturating mismatch count, CW bits
// master: the side feeding the checker; slave: the checker itself.
// ----------------------------------------------------------------------------
interface lfsr_checker_if #(
    parameter int CW = 16
);
    logic          din;
    logic          din_valid;
    logic          clr_cnt;
    logic          locked;
    logic          err;
    logic [CW-1:0] err_count;

    modport master (
        output din, din_valid, clr_cnt,
        input  locked, err, err_count
    );

    modport slave (
        input  din, din_valid, clr_cnt,
        output locked, err, err_count
    );
endinterface

// File: rtl/lfsr_history.sv
// ----------------------------------------------------------------------------
// lfsr_history
// N-bit history shift register of the sequence checker, newest bit at h[0].
//   clk, r       : clock, synchronous active-high reset (history cleared)
//   shift_i      : shift one bit in on this edge
//   sel_pred_i   : 1 = shift in the own prediction (flywheel), 0 = din_i
//   din_i        : received bit
//   pred_o       : predicted next bit from the current history
//   zero_o       : history is all zeros
// ----------------------------------------------------------------------------
module lfsr_history
    import lfsr_pkg::*;
#(
    parameter int N     = LFSR_N,
    parameter int TAP_A = LFSR_TAP_A,
    parameter int TAP_B = LFSR_TAP_B
) (
    input  logic clk,
    input  logic r,
    input  logic shift_i,
    input  logic sel_pred_i,
    input  logic din_i,
    output logic pred_o,
    output logic zero_o
);

    logic [N-1:0] h_q;
    logic [N-1:0] h_d;
    logic         bit_in;

    always_comb begin
        bit_in = sel_pred_i ? pred_o : din_i;
        h_d    = h_q;
        if (shift_i) begin
            h_d = {h_q[N-2:0], bit_in};
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            h_q <= '0;
        end else begin
            h_q <= h_d;
        end
    end

    assign pred_o = lfsr_predict(LFSR_MAX_N'(h_q), N, TAP_A, TAP_B);
    assign zero_o = (h_q == '0);

endmodule

// File: rtl/lfsr_checker.sv
// ----------------------------------------------------------------------------
// lfsr_checker
// Self-synchronising checker for the Galois LFSR generator's serial output.
// Fills its history with N received bits, verifies LOCK_CNT consecutive
// correct predictions, then free-runs on its own predictions (flywheel) and
// counts every received bit that disagrees.
//   clk : rising-edge clock
//   r   : synchronous active-high reset
//   bus : lfsr_checker_if.slave (din, din_valid, clr_cnt in;
//         locked, err, err_count out)
// ----------------------------------------------------------------------------
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int N        = LFSR_N,
    parameter int TAP_A    = LFSR_TAP_A,
    parameter int TAP_B    = LFSR_TAP_B,
    parameter int LOCK_CNT = 32,
    parameter int LOSS_CNT = 4,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          r,
    lfsr_checker_if.slave bus
);

    localparam int FW = $clog2(N + 1);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);

    localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(LOSS_CNT - 1);

    state_e        state_q,  state_d;
    logic [FW-1:0] fill_q,   fill_d;
    logic [GW-1:0] good_q,   good_d;
    logic [BW-1:0] bad_q,    bad_d;
    logic          locked_q, locked_d;
    logic          err_q,    err_d;
    logic [CW-1:0] cnt_q,    cnt_d;

    logic shift_en;
    logic sel_pred;
    logic pred;
    logic hist_zero;
    logic hit;

    lfsr_history #(
        .N     (N),
        .TAP_A (TAP_A),
        .TAP_B (TAP_B)
    ) u_history (
        .clk        (clk),
        .r          (r),
        .shift_i    (shift_en),
        .sel_pred_i (sel_pred),
        .din_i      (bus.din),
        .pred_o     (pred),
        .zero_o     (hist_zero)
    );

    assign hit = (bus.din == pred);

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        good_d   = good_q;
        bad_d    = bad_q;
        locked_d = locked_q;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        shift_en = 1'b0;
        sel_pred = 1'b0;

        if (bus.din_valid) begin
            shift_en = 1'b1;
            case (state_q)
                ST_FILL: begin
                    if (fill_q == FILL_LAST) begin
                        state_d = ST_VERIFY;
                        fill_d  = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                ST_VERIFY: begin
                    // An all-zero history predicts zeros forever; never
                    // accept it as a lock.
                    if (hit && !hist_zero) begin
                        if (good_q == GOOD_LAST) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                            good_d   = '0;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: the history follows the prediction so one
                    // corrupted line bit produces exactly one error.
                    sel_pred = 1'b1;
                    if (hit) begin
                        bad_d = '0;
                    end else begin
                        err_d = 1'b1;
                        if (cnt_q != {CW{1'b1}}) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (bad_q == BAD_LAST) begin
                            state_d  = ST_FILL;
                            locked_d = 1'b0;
                            fill_d   = '0;
                            bad_d    = '0;
                        end else begin
                            bad_d = bad_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d  = ST_FILL;
                    locked_d = 1'b0;
                end
            endcase
        end

        // Clear beats a coincident count; the err pulse is unaffected.
        if (bus.clr_cnt) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state_q  <= ST_FILL;
            fill_q   <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err       = err_q;
    assign bus.err_count = cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// ----------------------------------------------------------------------------
// tb_lfsr_checker
// Drives a CW=16 and a CW=4 checker with the same stimulus: a Galois LFSR
// generator stream with injected bit errors, gaps, clears and resets. A
// queue-based model of the checking rules provides the expected outputs.
// ----------------------------------------------------------------------------
module tb_lfsr_checker;
    import lfsr_pkg::*;

    localparam int N        = LFSR_N;
    localparam int TAP_A    = LFSR_TAP_A;
    localparam int TAP_B    = LFSR_TAP_B;
    localparam int LOCK_CNT = 32;
    localparam int LOSS_CNT = 4;
    localparam logic [N-1:0] GEN_MASK =
        (N'(1) << TAP_B) | (N'(1) << TAP_A) | N'(1);

    logic clk = 1'b0;
    logic r;

    always #5 clk = ~clk;

    lfsr_checker_if #(.CW(16)) bus16 ();
    lfsr_checker_if #(.CW(4))  bus4 ();

    lfsr_checker #(
        .N(N), .TAP_A(TAP_A), .TAP_B(TAP_B),
        .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CW(16)
    ) dut16 (
        .clk (clk),
        .r   (r),
        .bus (bus16.slave)
    );

    lfsr_checker #(
        .N(N), .TAP_A(TAP_A), .TAP_B(TAP_B),
        .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CW(4)
    ) dut4 (
        .clk (clk),
        .r   (r),
        .bus (bus4.slave)
    );

    int errors = 0;
    int checks = 0;

    // Generator: Galois LFSR, output q[N-1]
    logic [N-1:0] gen_q;

    // Reference model state
    bit hist[$];        // hist[0] is the newest bit
    int m_mode;         // 0 fill, 1 verify, 2 locked
    int m_fill, m_good, m_bad;
    bit m_locked, m_err;
    int m_cnt16, m_cnt4;

    function automatic bit gen_bit();
        bit o;
        o = gen_q[N-1];
        gen_q = {gen_q[N-2:0], 1'b0} ^ (o ? GEN_MASK : '0);
        return o;
    endfunction

    function automatic bit model_pred();
        return hist[N-TAP_B-1] ^ hist[N-TAP_A-1] ^ hist[N-1];
    endfunction

    function automatic bit model_zero();
        foreach (hist[i]) if (hist[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void push_hist(input bit b);
        hist.push_front(b);
        void'(hist.pop_back());
    endfunction

    function automatic void model_clock(input bit rst, input bit vld,
                                        input bit d, input bit clr);
        bit p;
        bit z;
        if (rst) begin
            hist = {};
            repeat (N) hist.push_back(1'b0);
            m_mode = 0; m_fill = 0; m_good = 0; m_bad = 0;
            m_locked = 0; m_err = 0; m_cnt16 = 0; m_cnt4 = 0;
            return;
        end
        m_err = 0;
        if (vld) begin
            p = model_pred();
            z = model_zero();
            if (m_mode == 0) begin
                push_hist(d);
                m_fill++;
                if (m_fill == N) begin m_mode = 1; m_fill = 0; end
            end else if (m_mode == 1) begin
                push_hist(d);
                if (d == p && !z) m_good++; else m_good = 0;
                if (m_good == LOCK_CNT) begin
                    m_mode = 2; m_locked = 1; m_good = 0;
                end
            end else begin
                push_hist(p);
                if (d == p) begin
                    m_bad = 0;
                end else begin
                    m_err = 1;
                    if (m_cnt16 < 65535) m_cnt16++;
                    if (m_cnt4 < 15) m_cnt4++;
                    m_bad++;
                    if (m_bad == LOSS_CNT) begin
                        m_mode = 0; m_locked = 0; m_fill = 0; m_bad = 0;
                    end
                end
            end
        end
        if (clr) begin m_cnt16 = 0; m_cnt4 = 0; end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit rst, input bit vld, input bit d, input bit clr);
        r = rst;
        bus16.din = d; bus16.din_valid = vld; bus16.clr_cnt = clr;
        bus4.din  = d; bus4.din_valid  = vld; bus4.clr_cnt  = clr;
        @(posedge clk);
        model_clock(rst, vld, d, clr);
        #1;
        check("locked16", 32'(bus16.locked),    32'(m_locked));
        check("err16",    32'(bus16.err),       32'(m_err));
        check("cnt16",    32'(bus16.err_count), 32'(m_cnt16));
        check("locked4",  32'(bus4.locked),     32'(m_locked));
        check("err4",     32'(bus4.err),        32'(m_err));
        check("cnt4",     32'(bus4.err_count),  32'(m_cnt4));
    endtask

    task automatic send(input bit inv);
        bit b;
        b = gen_bit();
        cycle(1'b0, 1'b1, b ^ inv, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'($urandom), 1'b0);
    endtask

    initial begin
        bit b;
        bit v;
        bit inv;
        bit clr;

        r = 1'b1;
        bus16.din = 1'b0; bus16.din_valid = 1'b0; bus16.clr_cnt = 1'b0;
        bus4.din  = 1'b0; bus4.din_valid  = 1'b0; bus4.clr_cnt  = 1'b0;
        gen_q = N'(4'b1000);

        // Reset state
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_locked", 32'(bus16.locked), 32'd0);
        check("rst_cnt",    32'(bus16.err_count), 32'd0);

        // Lock after exactly N+LOCK_CNT clean bits, then 1000 clean bits
        repeat (N + LOCK_CNT - 1) send(1'b0);
        check("lock_before", 32'(bus16.locked), 32'd0);
        send(1'b0);
        check("lock_at", 32'(bus16.locked), 32'd1);
        repeat (1000 - N - LOCK_CNT) send(1'b0);
        check("clean_cnt", 32'(bus16.err_count), 32'd0);

        // Single error while locked
        repeat (147) send(1'b0);
        send(1'b1);
        check("single_err", 32'(bus16.err), 32'd1);
        check("single_cnt", 32'(bus16.err_count), 32'd1);
        send(1'b0);
        check("single_err_off", 32'(bus16.err), 32'd0);
        repeat (499) send(1'b0);
        check("single_locked", 32'(bus16.locked), 32'd1);
        check("single_cnt_hold", 32'(bus16.err_count), 32'd1);

        // Loss and relock
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_cnt", 32'(bus16.err_count), 32'd0);
        repeat (LOSS_CNT - 1) send(1'b1);
        check("loss_not_yet", 32'(bus16.locked), 32'd1);
        send(1'b1);
        check("loss_locked", 32'(bus16.locked), 32'd0);
        check("loss_cnt", 32'(bus16.err_count), 32'd4);
        repeat (N + LOCK_CNT - 1) send(1'b0);
        check("relock_before", 32'(bus16.locked), 32'd0);
        send(1'b0);
        check("relock_at", 32'(bus16.locked), 32'd1);
        check("relock_cnt", 32'(bus16.err_count), 32'd4);

        // All-zero stream never locks
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (200) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("zero_locked", 32'(bus16.locked), 32'd0);
        check("zero_cnt", 32'(bus16.err_count), 32'd0);

        // Gapped stream: valid every other cycle
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (N + LOCK_CNT - 1) begin
            send(1'b0);
            idle();
        end
        check("gap_before", 32'(bus16.locked), 32'd0);
        send(1'b0);
        check("gap_lock", 32'(bus16.locked), 32'd1);
        idle();

        // Saturation (CW=4) and clear coincident with an error
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (20) begin
            send(1'b1);
            repeat (10) send(1'b0);
        end
        check("sat_cnt4", 32'(bus4.err_count), 32'd15);
        check("sat_cnt16", 32'(bus16.err_count), 32'd20);
        check("sat_locked", 32'(bus4.locked), 32'd1);
        b = gen_bit();
        cycle(1'b0, 1'b1, ~b, 1'b1);
        check("clr_err", 32'(bus4.err), 32'd1);
        check("clr_cnt4", 32'(bus4.err_count), 32'd0);
        check("clr_cnt16", 32'(bus16.err_count), 32'd0);
        repeat (10) send(1'b0);

        // Reset while locked with a non-zero count
        repeat (3) begin
            send(1'b1);
            repeat (5) send(1'b0);
        end
        check("mid_cnt", 32'(bus16.err_count), 32'd3);
        check("mid_locked", 32'(bus16.locked), 32'd1);
        cycle(1'b1, 1'b1, 1'($urandom), 1'b0);
        check("mid_rst_locked", 32'(bus16.locked), 32'd0);
        check("mid_rst_err", 32'(bus16.err), 32'd0);
        check("mid_rst_cnt", 32'(bus16.err_count), 32'd0);
        repeat (N + LOCK_CNT - 1) send(1'b0);
        check("mid_relock_before", 32'(bus16.locked), 32'd0);
        send(1'b0);
        check("mid_relock", 32'(bus16.locked), 32'd1);

        // Random gaps, errors and clears against the model
        repeat (3000) begin
            v   = ($urandom_range(0, 3) != 0);
            inv = ($urandom_range(0, 15) == 0);
            clr = ($urandom_range(0, 199) == 0);
            if (v) begin
                b = gen_bit();
                cycle(1'b0, 1'b1, b ^ inv, clr);
            end else begin
                cycle(1'b0, 1'b0, 1'($urandom), clr);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
